// File: rtl/pooling_ctrl_seq.sv
// Control sequencer for the max-pooling datapath: walks a row-streamed fmap and
// issues one registered ctrl word per accepted element.
module pooling_ctrl_seq #(
    parameter int unsigned CTRL_WIDTH      = 7,
    parameter int unsigned KERNEL_SIZE_W   = 2,
    parameter int unsigned STRIDE_WIDTH    = 2,
    parameter int unsigned ROW_COUNT_WIDTH = 6,
    parameter int unsigned PIPE_DEPTH      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KERNEL_SIZE_W-1:0]   cfg_kernel,
    input  logic [STRIDE_WIDTH-1:0]    cfg_stride,
    input  logic [ROW_COUNT_WIDTH-1:0] cfg_in_w,
    input  logic [ROW_COUNT_WIDTH-1:0] cfg_in_h,
    input  logic                       cfg_pad,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       in_ready,
    output logic [CTRL_WIDTH-1:0]      ctrl,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam int unsigned RW      = ROW_COUNT_WIDTH;
    localparam int unsigned GW      = ROW_COUNT_WIDTH + 1;
    localparam int unsigned DRAIN_W = $clog2(PIPE_DEPTH + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state;
    logic [KERNEL_SIZE_W-1:0] k_q;
    logic [STRIDE_WIDTH-1:0]  s_q;
    logic [RW-1:0]            w_q;
    logic [RW-1:0]            h_q;
    logic                     pad_q;
    logic [RW-1:0]            c_q;
    logic [RW-1:0]            r_q;
    logic [KERNEL_SIZE_W-1:0] v_q;
    logic [STRIDE_WIDTH-1:0]  sk_q;
    logic [DRAIN_W-1:0]       drain_q;

    logic                  cfg_bad;
    logic                  hsel;
    logic                  v_last;
    logic                  trail;
    logic                  last_row;
    logic                  last_col;
    logic                  push_b;
    logic                  pv_b;
    logic                  prow_b;
    logic [CTRL_WIDTH-1:0] ctrl_next;

    assign in_ready = (state == S_RUN) && in_valid && out_ready;

    // Window decode for the element currently offered.
    always_comb begin
        cfg_bad  = (k_q < KERNEL_SIZE_W'(2)) || (s_q == '0) ||
                   (RW'(s_q) > RW'(k_q)) || (w_q < RW'(k_q)) || (h_q < RW'(k_q));
        hsel     = (c_q >= (RW'(k_q) - RW'(1))) && (sk_q == '0);
        v_last   = (v_q == (k_q - KERNEL_SIZE_W'(1)));
        // Row belongs to a window group that cannot be completed from H rows.
        trail    = (GW'(r_q) + GW'(k_q) - GW'(v_q)) > GW'(h_q);
        last_row = (r_q == (h_q - RW'(1)));
        last_col = (c_q == (w_q - RW'(1)));
        push_b   = hsel && !v_last;
        pv_b     = hsel && v_last;
        prow_b   = 1'b0;
        if (trail && pad_q && last_row) begin
            push_b = 1'b0;
            pv_b   = hsel;
            prow_b = hsel;
        end
        ctrl_next = CTRL_WIDTH'({prow_b, pv_b, (v_q != '0), (hsel && (v_q != '0)),
                                 push_b, hsel, 1'b1});
        if (trail && !pad_q) begin
            ctrl_next = CTRL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            pad_q   <= 1'b0;
            c_q     <= '0;
            r_q     <= '0;
            v_q     <= '0;
            sk_q    <= '0;
            drain_q <= '0;
            ctrl    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            ctrl <= '0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q     <= cfg_kernel;
                        s_q     <= cfg_stride;
                        w_q     <= cfg_in_w;
                        h_q     <= cfg_in_h;
                        pad_q   <= cfg_pad;
                        c_q     <= '0;
                        r_q     <= '0;
                        v_q     <= '0;
                        sk_q    <= '0;
                        drain_q <= '0;
                        cfg_err <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_ready) begin
                        ctrl <= ctrl_next;
                        if (last_col) begin
                            c_q  <= '0;
                            sk_q <= '0;
                            v_q  <= v_last ? '0 : v_q + KERNEL_SIZE_W'(1);
                            if (last_row) begin
                                r_q     <= '0;
                                v_q     <= '0;
                                drain_q <= '0;
                                state   <= S_DRAIN;
                            end else begin
                                r_q <= r_q + RW'(1);
                            end
                        end else begin
                            c_q <= c_q + RW'(1);
                            // Skip counter spaces window ends S columns apart.
                            if (hsel) begin
                                sk_q <= s_q - STRIDE_WIDTH'(1);
                            end else if (sk_q != '0) begin
                                sk_q <= sk_q - STRIDE_WIDTH'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // First drain cycle carries the last ctrl word, then PIPE_DEPTH more.
                    if (drain_q == DRAIN_W'(PIPE_DEPTH)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_ctrl_seq.sv
// Bench for pooling_ctrl_seq: table of tile configs, per-cycle ctrl scoreboard,
// plus a hand-written mid-tile reset sequence.
module tb_pooling_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cfg_kernel;
    logic [1:0] cfg_stride;
    logic [5:0] cfg_in_w;
    logic [5:0] cfg_in_h;
    logic       cfg_pad;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready;
    logic [6:0] ctrl;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int tests  = 0;
    int failed = 0;

    pooling_ctrl_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_kernel(cfg_kernel),
        .cfg_stride(cfg_stride),
        .cfg_in_w  (cfg_in_w),
        .cfg_in_h  (cfg_in_h),
        .cfg_pad   (cfg_pad),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    k;
        int    s;
        int    w;
        int    h;
        bit    pad;
        bit    err;
        int    stall_at;
        int    stall_n;
        bit    restart;
        int    exp_pooled;
        int    exp_lat;
    } tc_t;

    tc_t tcs[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference ctrl word for element (c,r), written with plain modulo arithmetic.
    function automatic logic [6:0] ref_ctrl(input int k, input int s, input int h,
                                            input bit pad, input int c, input int r);
        bit hs;
        bit tr;
        int v;
        logic [6:0] x;
        hs = (c >= k - 1) && (((c - k + 1) % s) == 0);
        v  = r % k;
        tr = r >= (h - (h % k));
        if (tr && !pad) return 7'b0000001;
        x    = '0;
        x[0] = 1'b1;
        x[1] = hs;
        x[2] = hs && (v != k - 1);
        x[3] = hs && (v != 0);
        x[4] = (v != 0);
        x[5] = hs && (v == k - 1);
        if (tr && pad && r == h - 1) begin
            x[2] = 1'b0;
            x[5] = hs;
            x[6] = hs;
        end
        return x;
    endfunction

    task automatic run_case(input tc_t t);
        int         c;
        int         r;
        int         elems;
        int         total;
        int         stall_left;
        int         pooled;
        int         dones;
        int         m;
        bit         run_m;
        bit         stalled;
        bit         exp_rdy;
        logic [6:0] exp_ctrl;
        logic [6:0] q[$];
        c = 0; r = 0; elems = 0; pooled = 0; dones = 0;
        total      = t.err ? 0 : t.w * t.h;
        stall_left = t.stall_n;
        @(posedge clk); #1;
        cfg_kernel = 2'(t.k);
        cfg_stride = 2'(t.s);
        cfg_in_w   = 6'(t.w);
        cfg_in_h   = 6'(t.h);
        cfg_pad    = t.pad;
        start      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        // Scramble cfg after start: the latched copy must be used.
        start      = 1'b0;
        cfg_kernel = 2'd1;
        cfg_stride = 2'd0;
        cfg_in_w   = 6'd0;
        cfg_in_h   = 6'd0;
        cfg_pad    = ~t.pad;
        in_valid   = 1'b1;
        q.push_back(7'd0);
        for (int n = 1; n <= t.exp_lat + 4; n++) begin
            m         = n - 1;
            start     = t.restart && (m == 1);
            stalled   = (elems == t.stall_at) && (stall_left > 0);
            out_ready = !stalled;
            @(negedge clk);
            run_m    = !t.err && (m >= 1) && (elems < total);
            exp_rdy  = run_m && out_ready;
            exp_ctrl = q.pop_front();
            check($sformatf("%s ctrl m=%0d", t.name, m), int'(ctrl), int'(exp_ctrl));
            check($sformatf("%s in_ready m=%0d", t.name, m), int'(in_ready), int'(exp_rdy));
            check($sformatf("%s done m=%0d", t.name, m), int'(done), int'(m == t.exp_lat));
            check($sformatf("%s busy m=%0d", t.name, m), int'(busy), int'(m <= t.exp_lat));
            check($sformatf("%s cfg_err m=%0d", t.name, m), int'(cfg_err), int'(t.err && m >= 1));
            if (ctrl[5]) pooled++;
            if (done) dones++;
            if (exp_rdy) begin
                q.push_back(ref_ctrl(t.k, t.s, t.h, t.pad, c, r));
                elems++;
                c++;
                if (c == t.w) begin
                    c = 0;
                    r++;
                end
            end else begin
                q.push_back(7'd0);
                if (run_m && !out_ready) stall_left--;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s pooled", t.name), pooled, t.exp_pooled);
        check($sformatf("%s done_count", t.name), dones, 1);
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    // Reset while element 7 of a 2x2/4x4 tile is being accepted.
    task automatic reset_mid_tile();
        int accepts;
        int dones;
        accepts = 0;
        dones   = 0;
        @(posedge clk); #1;
        cfg_kernel = 2'd2; cfg_stride = 2'd2; cfg_in_w = 6'd4; cfg_in_h = 6'd4; cfg_pad = 1'b0;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 40 && accepts < 7; i++) begin
            @(negedge clk);
            if (in_ready) accepts++;
        end
        check("rst accepts_before_reset", accepts, 7);
        reset = 1'b1;
        @(negedge clk);
        check("rst ctrl", int'(ctrl), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dones++;
            check("rst idle_busy", int'(busy), 0);
        end
        check("rst no_done", dones, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        tcs[0] = '{"k2s2",    2, 2, 4, 4, 1'b0, 1'b0, -1, 0, 1'b0, 4, 21};
        tcs[1] = '{"k3s1",    3, 1, 5, 3, 1'b0, 1'b0, -1, 0, 1'b1, 3, 20};
        tcs[2] = '{"pad1",    2, 2, 4, 5, 1'b1, 1'b0, -1, 0, 1'b0, 6, 25};
        tcs[3] = '{"pad0",    2, 2, 4, 5, 1'b0, 1'b0, -1, 0, 1'b0, 4, 25};
        tcs[4] = '{"stall",   2, 2, 4, 4, 1'b0, 1'b0,  4, 3, 1'b0, 4, 24};
        tcs[5] = '{"k3s2pad", 3, 2, 7, 5, 1'b1, 1'b0, -1, 0, 1'b0, 6, 40};
        tcs[6] = '{"s0err",   3, 0, 4, 4, 1'b0, 1'b1, -1, 0, 1'b1, 0, 1};
        tcs[7] = '{"sgtk",    2, 3, 4, 4, 1'b0, 1'b1, -1, 0, 1'b0, 0, 1};
        tcs[8] = '{"wltk",    2, 1, 1, 4, 1'b0, 1'b1, -1, 0, 1'b0, 0, 1};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_kernel = '0; cfg_stride = '0; cfg_in_w = '0; cfg_in_h = '0; cfg_pad = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset ctrl", int'(ctrl), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset cfg_err", int'(cfg_err), 0);
        check("reset in_ready", int'(in_ready), 0);

        for (int i = 0; i < 9; i++) begin
            run_case(tcs[i]);
        end
        reset_mid_tile();
        run_case(tcs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
